// File: rtl/piso_tx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : piso_tx_pkg
//  Description : Shared types for the PISO transmit scheduler: controller
//                state encoding and requester-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_tx_pkg;

    // Controller states: arbitration, serial shifting, inter-word idle gap
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Width of a requester index; never narrower than one bit
    function automatic int idw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index width for the default four-requester configuration
    localparam int IDW = idw_f(4);

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches upward from
//                ptr+1 with wrap-around and returns the first set request
//                as a one-hot grant plus its index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import piso_tx_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int IDW_L = idw_f(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDW_L-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDW_L-1:0] grant_idx,
    output logic             any
);

    logic [IDW_L-1:0] w_cand;

    // Walk the requesters starting just after the last winner; first hit wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_cand    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_cand = IDW_L'((int'(ptr) + off) % NREQ);
            if (!any && req[w_cand]) begin
                any           = 1'b1;
                grant_idx     = w_cand;
                grant[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/piso_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : piso_tx_scheduler
//  Description : Round-robin scheduler sharing one parallel-in/serial-out
//                shift datapath between NREQ word sources. Grants one
//                requester in IDLE, shifts its word out over WIDTH cycles
//                with first/last strobes and source ID, then optionally
//                idles for GAP cycles.
//  Options     : PISO_TX_PARITY_EN - append an even-parity bit to each frame
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_tx_scheduler
    import piso_tx_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int WIDTH     = 4,
    parameter  int GAP       = 0,
    parameter  int MSB_FIRST = 1,
    localparam int IDW_L     = idw_f(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    ser_out,
    output logic                    ser_valid,
    output logic                    ser_first,
    output logic                    ser_last,
    output logic [IDW_L-1:0]        ser_id,
    output logic                    busy
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_TX_PARITY_EN
    // Parity bit occupies the slot after the last data bit
    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH);
`else
    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);
`endif
    localparam logic [3:0]       c_gap_last = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [IDW_L-1:0] c_ptr_rst  = IDW_L'(NREQ - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [3:0]         gap_q,   gap_d;
    logic [IDW_L-1:0]   ptr_q,   ptr_d;
    logic [IDW_L-1:0]   id_q,    id_d;
`ifdef PISO_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic [NREQ-1:0]    w_grant;
    logic [IDW_L-1:0]   w_grant_idx;
    logic               w_any;
    logic [WIDTH-1:0]   w_word;

    rr_arbiter #(
        .NREQ      (NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    // One-hot mux selecting the granted requester's word
    always_comb begin
        w_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_word = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state, datapath update and output decode
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
`ifdef PISO_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        req_ready = '0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Reset suppresses the handshake so no word is accepted and then dropped
                if (!rst && w_any) begin
                    req_ready = w_grant;
                    shreg_d   = w_word;
                    id_d      = w_grant_idx;
                    ptr_d     = w_grant_idx;
                    cnt_d     = '0;
`ifdef PISO_TX_PARITY_EN
                    parity_d  = ^w_word;
`endif
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_first = (cnt_q == '0);
                ser_last  = (cnt_q == c_last_bit);
                ser_out   = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
`ifdef PISO_TX_PARITY_EN
                if (cnt_q == c_last_bit) begin
                    ser_out = parity_q;
                end
`endif
                shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                           : {1'b0, shreg_q[WIDTH-1:1]};
                if (cnt_q == c_last_bit) begin
                    cnt_d = '0;
                    gap_d = '0;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == c_gap_last) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; pointer restarts at NREQ-1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            ptr_q    <= c_ptr_rst;
            id_q     <= '0;
`ifdef PISO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
`ifdef PISO_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign ser_id = id_q;
    assign busy   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_piso_tx_scheduler
//  Description : Self-checking bench for piso_tx_scheduler. Two instances:
//                inst0 GAP=0 MSB-first, inst1 GAP=3 LSB-first. A frame-level
//                reference model predicts grants, busy/valid windows and the
//                serial bit sequence; a monitor collects frames and compares
//                them against the expected-frame queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int NI   = 2;
`ifdef PISO_TX_PARITY_EN
    localparam int PAR  = 1;
`else
    localparam int PAR  = 0;
`endif
    localparam int FL   = W + PAR;

    typedef struct {
        int          inst;
        int          id;
        logic [32:0] seq;
        int          len;
        int          start;
    } frame_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        rv  [NI];
    logic [NREQ*W-1:0]      rd  [NI];
    logic [NREQ-1:0]        rr  [NI];
    logic                   so  [NI];
    logic                   sv  [NI];
    logic                   sf  [NI];
    logic                   sl  [NI];
    logic [1:0]             sid [NI];
    logic                   bz  [NI];

    int      cyc     = 0;
    int      n_vec   = 0;
    int      n_fail  = 0;
    bit      chk_en  = 1'b0;
    bit      rst_nxt = 1'b1;

    bit          pend [NI][NREQ];
    logic [W-1:0] wrd [NI][NREQ];
    int      ptr_m     [NI];
    int      grant_t   [NI];
    int      next_free [NI];
    int      id_m      [NI];
    frame_t  expq[$];

    bit          inf  [NI];
    logic [32:0] got  [NI];
    int          glen [NI];
    int          gst  [NI];
    int          gid  [NI];

    piso_tx_scheduler #(.NREQ(NREQ), .WIDTH(W), .GAP(0), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .ser_first(sf[0]), .ser_last(sl[0]),
        .ser_id(sid[0]), .busy(bz[0])
    );

    piso_tx_scheduler #(.NREQ(NREQ), .WIDTH(W), .GAP(3), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .ser_first(sf[1]), .ser_last(sl[1]),
        .ser_id(sid[1]), .busy(bz[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit msb_of(input int k);
        return (k == 0);
    endfunction

    task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d cyc=%0d got=0x%0h expected=0x%0h", nm, k, cyc, act, exp);
        end
    endtask

    // Round-robin choice: first valid requester after the previous winner
    function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
        for (int o = 1; o <= NREQ; o++) begin
            if (v[(p + o) % NREQ]) return (p + o) % NREQ;
        end
        return -1;
    endfunction

    // Transmission-order bit sequence for a word (plus parity when enabled)
    function automatic logic [32:0] build(input int k, input logic [W-1:0] w);
        logic [32:0] s;
        s = '0;
        for (int j = 0; j < W; j++) begin
            s = {s[31:0], (msb_of(k) ? w[W-1-j] : w[j])};
        end
        if (PAR != 0) s = {s[31:0], ^w};
        return s;
    endfunction

    task automatic apply();
        rst = rst_nxt;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                rv[k][i]         = pend[k][i];
                rd[k][i*W +: W]  = wrd[k][i];
            end
        end
    endtask

    // Reference model: predicts handshakes and busy/valid windows per instance
    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            logic [NREQ-1:0] er;
            int     g;
            bit     eb, ev;
            frame_t f;
            er = '0;
            g  = -1;
            eb = (cyc > grant_t[k]) && (cyc < next_free[k]);
            ev = (cyc > grant_t[k]) && (cyc <= grant_t[k] + FL);
            if (!rst && cyc >= next_free[k]) g = rr_pick(ptr_m[k], rv[k]);
            if (g >= 0) er[g] = 1'b1;
            if (chk_en) begin
                check("req_ready", k, rr[k], er);
                check("busy", k, bz[k], eb);
                check("ser_valid", k, sv[k], ev);
                check("ser_id", k, sid[k], id_m[k]);
            end
            if (g >= 0) begin
                f.inst  = k;
                f.id    = g;
                f.seq   = build(k, wrd[k][g]);
                f.len   = FL;
                f.start = cyc + 1;
                expq.push_back(f);
                grant_t[k]   = cyc;
                next_free[k] = cyc + FL + 1 + gap_of(k);
                ptr_m[k]     = g;
                id_m[k]      = g;
                pend[k][g]   = 1'b0;
            end
            if (rst) begin
                ptr_m[k]     = NREQ - 1;
                grant_t[k]   = -1000;
                next_free[k] = cyc + 1;
                id_m[k]      = 0;
            end
        end
    endtask

    task automatic cycle_();
        @(posedge clk);
        #1;
        apply();
        @(negedge clk);
        model_step();
    endtask

    // Monitor: assembles frames off the serial line and pops the expected queue
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                inf[k] = 1'b0;
                for (int i = expq.size() - 1; i >= 0; i--) begin
                    if (expq[i].inst == k) expq.delete(i);
                end
            end else if (chk_en) begin
                if (sv[k]) begin
                    if (sf[k]) begin
                        check("frame_restart", k, inf[k], 0);
                        inf[k]  = 1'b1;
                        got[k]  = '0;
                        glen[k] = 0;
                        gst[k]  = cyc;
                        gid[k]  = int'(sid[k]);
                    end else begin
                        check("orphan_bit", k, inf[k], 1);
                    end
                    got[k]  = {got[k][31:0], so[k]};
                    glen[k] = glen[k] + 1;
                    if (sl[k]) begin
                        int idx;
                        idx = -1;
                        for (int i = 0; i < expq.size(); i++) begin
                            if (idx < 0 && expq[i].inst == k) idx = i;
                        end
                        check("frame_expected", k, (idx >= 0), 1);
                        if (idx >= 0) begin
                            check("frame_bits", k, got[k], expq[idx].seq);
                            check("frame_len", k, glen[k], expq[idx].len);
                            check("frame_start", k, gst[k], expq[idx].start);
                            check("frame_id", k, gid[k], expq[idx].id);
                            expq.delete(idx);
                        end
                        inf[k] = 1'b0;
                    end
                end else begin
                    check("idle_lines", k, {so[k], sf[k], sl[k]}, 3'b000);
                end
            end
        end
    end

    initial begin
        int left;
        for (int k = 0; k < NI; k++) begin
            ptr_m[k] = NREQ - 1; grant_t[k] = -1000; next_free[k] = 0; id_m[k] = 0;
            inf[k] = 1'b0; got[k] = '0; glen[k] = 0; gst[k] = 0; gid[k] = 0;
            for (int i = 0; i < NREQ; i++) begin
                pend[k][i] = 1'b0;
                wrd[k][i]  = '0;
            end
        end
        apply();

        // Reset; checking starts once the first reset edge has landed
        rst_nxt = 1'b1;
        cycle_();
        chk_en = 1'b1;
        repeat (2) cycle_();
        rst_nxt = 1'b0;

        // Single word 1011 from requester 0
        pend[0][0] = 1'b1; wrd[0][0] = 4'b1011;
        repeat (8) cycle_();

        // All four requesters at once after a fresh reset: order 0,1,2,3
        rst_nxt = 1'b1; cycle_(); rst_nxt = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[0][i] = 1'b1;
            wrd[0][i]  = W'(i + 1);
        end
        for (int n = 0; n < 40; n++) begin
            if (pend[0][0] | pend[0][1] | pend[0][2] | pend[0][3]) cycle_();
        end
        check("all4_drained", 0, {pend[0][3], pend[0][2], pend[0][1], pend[0][0]}, 4'b0000);
        repeat (8) cycle_();

        // Back-to-back words from requester 2 on the GAP=3 instance
        for (int n = 0; n < 30; n++) begin
            if (!pend[1][2]) begin
                pend[1][2] = 1'b1;
                wrd[1][2]  = W'($urandom);
            end
            cycle_();
        end
        pend[1][2] = 1'b0;
        repeat (12) cycle_();

        // Reset mid-frame after the second bit, then requester 3 alone
        pend[0][0] = 1'b1; wrd[0][0] = 4'b1011;
        repeat (3) cycle_();
        rst_nxt = 1'b1; cycle_(); rst_nxt = 1'b0;
        pend[0][3] = 1'b1; wrd[0][3] = 4'b1001;
        repeat (8) cycle_();

        // Requester 1 arrives while requester 0 is shifting
        pend[0][0] = 1'b1; wrd[0][0] = 4'b0110;
        repeat (2) cycle_();
        pend[0][1] = 1'b1; wrd[0][1] = 4'b1101;
        repeat (12) cycle_();

        // Randomized traffic with occasional withdrawals
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NI; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!pend[k][i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            pend[k][i] = 1'b1;
                            wrd[k][i]  = W'($urandom);
                        end
                    end else if ($urandom_range(0, 49) == 0) begin
                        pend[k][i] = 1'b0;
                    end
                end
            end
            cycle_();
        end

        // Drain outstanding requests and frames
        repeat (80) cycle_();
        for (int k = 0; k < NI; k++) begin
            left = 0;
            for (int i = 0; i < expq.size(); i++) begin
                if (expq[i].inst == k) left++;
            end
            check("leftover_frames", k, left, 0);
            check("open_frame", k, inf[k], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
